// File: rtl/multiplier_pkg.sv
// Shared definitions for the shift-and-add multiplier blocks.
package multiplier_pkg;

  // Two-bit state encoding. Code 2'b11 is unused and decodes as IDLE.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } multiplier_state_t;

endpackage

// File: rtl/multiplier_controller_fsm.sv
// Control state machine for the shift-and-add multiplier.
// Sequences operand load, per-bit shift/accumulate and the iteration
// down-counter. Outputs are Mealy and are all forced low while reset is high.
module multiplier_controller_fsm
  import multiplier_pkg::*;
(
  input  logic clock,
  input  logic reset,
  input  logic start,
  input  logic counter_is_zero,
  output logic ready,
  output logic datapath_do_init,
  output logic datapath_do_shift,
  output logic counter_do_preset,
  output logic counter_do_decrement
);

  multiplier_state_t state_reg;
  multiplier_state_t state_next;

  // State register; reset drops straight to IDLE without waiting for a clock.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state and Mealy output decode from current state and inputs.
  always_comb begin
    state_next           = state_reg;
    ready                = 1'b0;
    datapath_do_init     = 1'b0;
    datapath_do_shift    = 1'b0;
    counter_do_preset    = 1'b0;
    counter_do_decrement = 1'b0;

    case (state_reg)
      RUN: begin
        // The last shift happens in the cycle the counter reads zero,
        // so the counter is only decremented while it is still non-zero.
        datapath_do_shift    = 1'b1;
        counter_do_decrement = !counter_is_zero;
        if (counter_is_zero) begin
          state_next = DONE;
        end
      end
      DONE: begin
        // The product stays valid through the restart cycle.
        ready = 1'b1;
        if (start) begin
          datapath_do_init  = 1'b1;
          counter_do_preset = 1'b1;
          state_next        = RUN;
        end
      end
      default: begin
        // IDLE, and the unused encoding, which behaves identically.
        if (start) begin
          datapath_do_init  = 1'b1;
          counter_do_preset = 1'b1;
          state_next        = RUN;
        end
      end
    endcase

    // Reset masks every output immediately, independent of start.
    if (reset) begin
      state_next           = IDLE;
      ready                = 1'b0;
      datapath_do_init     = 1'b0;
      datapath_do_shift    = 1'b0;
      counter_do_preset    = 1'b0;
      counter_do_decrement = 1'b0;
    end
  end

endmodule

// File: tb/tb_multiplier_controller_fsm.sv
// Scoreboard bench for multiplier_controller_fsm. Stimulus pushes the
// hand-computed output vector {ready, init, shift, preset, decrement}
// into a queue; a monitor pops and compares against the DUT outputs.
module tb_multiplier_controller_fsm;

  logic clock;
  logic reset;
  logic start;
  logic counter_is_zero;
  logic ready;
  logic datapath_do_init;
  logic datapath_do_shift;
  logic counter_do_preset;
  logic counter_do_decrement;

  typedef struct {
    string      name;
    logic [4:0] exp;
  } expect_t;

  expect_t sb_q[$];
  event    chk_ev;
  int      n_checks = 0;
  int      n_fail   = 0;

  multiplier_controller_fsm dut (
    .clock                (clock),
    .reset                (reset),
    .start                (start),
    .counter_is_zero      (counter_is_zero),
    .ready                (ready),
    .datapath_do_init     (datapath_do_init),
    .datapath_do_shift    (datapath_do_shift),
    .counter_do_preset    (counter_do_preset),
    .counter_do_decrement (counter_do_decrement)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Monitor: each time stimulus flags a sample point, pop and compare.
  initial begin
    expect_t    e;
    logic [4:0] act;
    forever begin
      @(chk_ev);
      while (sb_q.size() > 0) begin
        e   = sb_q.pop_front();
        act = {ready, datapath_do_init, datapath_do_shift,
               counter_do_preset, counter_do_decrement};
        n_checks++;
        if (act !== e.exp) begin
          n_fail++;
          $display("FAIL %s: got %b expected %b", e.name, act, e.exp);
        end else begin
          $display("ok   %s: %b", e.name, act);
        end
      end
    end
  end

  // Let combinational outputs settle, then hand an expectation to the monitor.
  task automatic expect_out(input string name, input logic [4:0] exp);
    expect_t e;
    #1;
    e.name = name;
    e.exp  = exp;
    sb_q.push_back(e);
    -> chk_ev;
    #1;
  endtask

  // Advance past the next rising edge, sampling well away from it.
  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    counter_is_zero = 1'b0;

    // Reset hold
    #2;
    expect_out("reset_hold", 5'b00000);
    start = 1'b1;
    expect_out("reset_masks_start", 5'b00000);
    tick();
    expect_out("reset_across_edge", 5'b00000);
    start = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    tick();
    expect_out("idle_1", 5'b00000);
    tick();
    expect_out("idle_2", 5'b00000);

    // Start from IDLE, mid-cycle
    start = 1'b1;
    expect_out("idle_start", 5'b01010);
    tick();
    start = 1'b0;
    expect_out("run_first", 5'b00101);

    // Iteration
    for (int i = 0; i < 3; i++) begin
      tick();
      expect_out($sformatf("run_iter%0d", i), 5'b00101);
    end
    counter_is_zero = 1'b1;
    expect_out("run_last_shift", 5'b00100);
    tick();
    counter_is_zero = 1'b0;
    expect_out("done_ready", 5'b10000);
    tick();
    expect_out("done_hold", 5'b10000);
    counter_is_zero = 1'b1;
    expect_out("done_ignores_zero", 5'b10000);
    tick();
    expect_out("done_hold2", 5'b10000);
    counter_is_zero = 1'b0;

    // Restart from DONE
    start = 1'b1;
    expect_out("done_restart", 5'b11010);
    tick();
    start = 1'b0;
    expect_out("restart_run", 5'b00101);

    // Start ignored in RUN
    start = 1'b1;
    expect_out("run_ignores_start", 5'b00101);
    tick();
    expect_out("run_no_reinit", 5'b00101);
    start = 1'b0;
    tick();
    expect_out("run_continue", 5'b00101);

    // Reset mid-RUN
    reset = 1'b1;
    expect_out("reset_mid_run", 5'b00000);
    tick();
    expect_out("reset_mid_run_edge", 5'b00000);
    reset = 1'b0;
    expect_out("after_reset_idle", 5'b00000);
    tick();
    expect_out("after_reset_idle_edge", 5'b00000);

    // Start held high across edges after reset: one init, then RUN
    start = 1'b1;
    expect_out("start_held_init", 5'b01010);
    tick();
    expect_out("start_held_run", 5'b00101);
    start = 1'b0;

    // Drain the scoreboard with a bounded wait
    begin
      int budget = 20;
      while (sb_q.size() > 0 && budget > 0) begin
        tick();
        budget--;
      end
      if (sb_q.size() > 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL scoreboard_drain: %0d pending expected 0", sb_q.size());
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Watchdog
  initial begin
    #100000;
    $display("FAIL watchdog: timeout reached expected completion");
    $fatal(1, "watchdog");
  end

endmodule
